// File: rtl/word_entry_pkg.sv
// Shared constants and state type for the keypad front end and the game FSM.
// Latency: n/a (package only).
// Backpressure: n/a.
package word_entry_pkg;

  // Letters per secret word; the game FSM uses the same value.
  localparam int WORD_LEN = 5;
  localparam int WORD_W   = 8 * WORD_LEN;

  // letter_count width and its "word full" value.
  localparam int         CNT_W    = 3;
  localparam logic [2:0] CNT_FULL = 3'(WORD_LEN);

  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_Z    = 8'h5A;
  localparam logic [7:0] ASCII_CASE = 8'h20;

  typedef enum logic [1:0] {
    ST_HOST  = 2'd0,
    ST_START = 2'd1,
    ST_PLAY  = 2'd2,
    ST_WAIT  = 2'd3
  } entry_state_t;

endpackage

// File: rtl/ascii_letter_decode.sv
// Maps a keypad byte to an uppercase letter and its alphabet index.
// Latency: combinational.
// Backpressure: none.
// Ports: i_key_code (raw byte) -> o_is_letter, o_upper (0 when not a letter),
//        o_idx (0..25, meaningful only when o_is_letter is set).
module ascii_letter_decode
  import word_entry_pkg::*;
(
  input  logic [7:0] i_key_code,
  output logic       o_is_letter,
  output logic [7:0] o_upper,
  output logic [4:0] o_idx
);

  localparam logic [7:0] LOWER_A = ASCII_A + ASCII_CASE;
  localparam logic [7:0] LOWER_Z = ASCII_Z + ASCII_CASE;

  logic w_is_upper;
  logic w_is_lower;

  always_comb begin
    w_is_upper  = (i_key_code >= ASCII_A) && (i_key_code <= ASCII_Z);
    w_is_lower  = (i_key_code >= LOWER_A) && (i_key_code <= LOWER_Z);
    o_is_letter = w_is_upper || w_is_lower;
    if (w_is_lower) begin
      o_upper = i_key_code - ASCII_CASE;
    end else if (w_is_upper) begin
      o_upper = i_key_code;
    end else begin
      o_upper = 8'h00;
    end
    // 'A'..'Z' are 0x41..0x5A, so the low five bits run 1..26.
    o_idx = o_upper[4:0] - 5'd1;
  end

endmodule

// File: rtl/word_entry_ctrl.sv
// Keypad front end: collects the host's secret word, then issues one guess per
// game-FSM handshake.
// Latency: HOST keys update setWord/letter_count at the sampling edge;
//          key-to-guess is 2 edges minimum.
// Backpressure: one pending key is held until game_rdy=1 and red_busy=0; a newer
//          key overwrites it; no new guess until game_rdy has been seen low.
// Ports: clk/nRst; keypad strobes key_valid/key_code/key_del/key_enter;
//        game_rdy/red_busy/gameEnd from the game FSM; registered outputs
//        setWord, toggle_state, guess, letter_count, dup_guess, host_mode.
module word_entry_ctrl
  import word_entry_pkg::*;
(
  input  logic              clk,
  input  logic              nRst,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  input  logic              key_del,
  input  logic              key_enter,
  input  logic              game_rdy,
  input  logic              red_busy,
  input  logic              gameEnd,
  output logic [WORD_W-1:0] setWord,
  output logic              toggle_state,
  output logic [7:0]        guess,
  output logic [CNT_W-1:0]  letter_count,
  output logic              dup_guess,
  output logic              host_mode
);

  logic       w_is_letter;
  logic [7:0] w_upper;
  logic [4:0] w_idx;
  logic       w_letter_key;

  ascii_letter_decode u_dec (
    .i_key_code  (key_code),
    .o_is_letter (w_is_letter),
    .o_upper     (w_upper),
    .o_idx       (w_idx)
  );

  // enter/del outrank a letter arriving in the same cycle; gameEnd is handled first.
  assign w_letter_key = key_valid && w_is_letter && !key_enter && !key_del;

  entry_state_t      r_state;
  logic [WORD_W-1:0] r_set_word;
  logic [CNT_W-1:0]  r_count;
  logic [25:0]       r_mask;
  logic              r_pend_vld;
  logic [7:0]        r_pend_ltr;
  logic [4:0]        r_pend_idx;
  logic [7:0]        r_guess;
  logic              r_toggle;
  logic              r_dup;
  logic              r_host;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= ST_HOST;
      r_set_word <= '0;
      r_count    <= '0;
      r_mask     <= '0;
      r_pend_vld <= 1'b0;
      r_pend_ltr <= 8'h00;
      r_pend_idx <= 5'd0;
      r_guess    <= 8'h00;
      r_toggle   <= 1'b0;
      r_dup      <= 1'b0;
      r_host     <= 1'b1;
    end else begin
      // Pulse outputs default low every cycle.
      r_toggle <= 1'b0;
      r_dup    <= 1'b0;
      r_guess  <= 8'h00;
      if (gameEnd) begin
        r_state    <= ST_HOST;
        r_set_word <= '0;
        r_count    <= '0;
        r_mask     <= '0;
        r_pend_vld <= 1'b0;
        r_host     <= 1'b1;
      end else begin
        case (r_state)
          ST_HOST: begin
            if (key_enter) begin
              if (r_count == CNT_FULL) begin
                r_state  <= ST_START;
                r_toggle <= 1'b1;
                r_host   <= 1'b0;
              end
            end else if (key_del) begin
              if (r_count != '0) begin
                r_set_word <= {8'h00, r_set_word[WORD_W-1:8]};
                r_count    <= r_count - 3'd1;
              end
            end else if (w_letter_key && (r_count != CNT_FULL)) begin
              r_set_word <= {r_set_word[WORD_W-9:0], w_upper};
              r_count    <= r_count + 3'd1;
            end
          end
          ST_START: begin
            r_mask     <= '0;
            r_pend_vld <= 1'b0;
            r_state    <= ST_PLAY;
          end
          ST_PLAY: begin
            if (r_pend_vld && game_rdy && !red_busy) begin
              r_pend_vld <= 1'b0;
              if (r_mask[r_pend_idx]) begin
                r_dup <= 1'b1;
              end else begin
                r_guess             <= r_pend_ltr;
                r_mask[r_pend_idx]  <= 1'b1;
                r_state             <= ST_WAIT;
              end
            end
            // A key arriving as the old one issues becomes the next pending key.
            if (w_letter_key) begin
              r_pend_vld <= 1'b1;
              r_pend_ltr <= w_upper;
              r_pend_idx <= w_idx;
            end
          end
          ST_WAIT: begin
            // Holds here after game over too, since game_rdy stays high.
            if (!game_rdy) begin
              r_state <= ST_PLAY;
            end
            if (w_letter_key) begin
              r_pend_vld <= 1'b1;
              r_pend_ltr <= w_upper;
              r_pend_idx <= w_idx;
            end
          end
          default: r_state <= ST_HOST;
        endcase
      end
    end
  end

  assign setWord      = r_set_word;
  assign toggle_state = r_toggle;
  assign guess        = r_guess;
  assign letter_count = r_count;
  assign dup_guess    = r_dup;
  assign host_mode    = r_host;

endmodule

// File: doc/word_entry_ctrl.md
# word_entry_ctrl

Front-end controller directly upstream of the game-logic FSM. It collects the host's 5-letter secret word from a keypad byte stream into `setWord`, then pulses `toggle_state` to start the round. During play it turns player keypresses into single-cycle `guess` bytes, issued only when the game FSM is ready. It buffers one pending key, normalises case, and rejects letters already guessed.

## Interface
Parameters:
- `WORD_LEN`, 5: letters per word. Fixed at 5 by `setWord` width.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `nRst`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` valid this cycle.
- `key_code`  in  8  ASCII byte from keypad.
- `key_del`  in  1  backspace strobe.
- `key_enter`  in  1  confirm strobe.
- `game_rdy`  in  1  game FSM can take a guess.
- `red_busy`  in  1  game FSM is comparing letters.
- `gameEnd`  in  1  abort/restart request.
- `setWord`  out  40  secret word; first letter entered in [39:32], last in [7:0].
- `toggle_state`  out  1  one-cycle start pulse to the game FSM.
- `guess`  out  8  uppercase ASCII guess; non-zero for exactly one cycle per guess, else 0.
- `letter_count`  out  3  letters currently entered, 0..5.
- `dup_guess`  out  1  one-cycle pulse when a repeated letter is dropped.
- `host_mode`  out  1  1 while in HOST.

## Operation
- Letter decode:
  - 0x41–0x5A passes through.
  - 0x61–0x7A maps to byte − 0x20.
  - All other codes are ignored.
  - Index = letter − 0x41 (0..25).
- Input priority each cycle: `gameEnd` > `key_enter` > `key_del` > `key_valid`. Lower-priority strobes in the same cycle are dropped.
- States: HOST, START, PLAY, WAIT.
- HOST:
  - Valid letter with `letter_count`<5: `setWord` <= {`setWord`[31:0], letter}; count+1.
  - Letters at count 5 are ignored.
  - `key_del` with count>0: `setWord` <= {8'h00, `setWord`[39:8]}; count−1.
  - `key_enter` at count 5 -> START. At count<5 it is ignored.
  - Repeated letters are allowed in the word.
- START: `toggle_state`=1 for one cycle; clear used-letter mask and pending buffer; -> PLAY.
- PLAY:
  - A valid player letter loads a 1-deep pending register. A newer key overwrites an unissued one.
  - If pending is valid and `game_rdy`=1 and `red_busy`=0:
    - If the letter's mask bit is set: drop it, pulse `dup_guess`.
    - Otherwise: `guess` <= letter, set mask bit, clear pending, -> WAIT.
- WAIT: `guess` returns to 0. Stay until `game_rdy`=0 is sampled, then -> PLAY. Keys arriving during WAIT still load pending.
- Game over: after a win or loss, `game_rdy` stays high and the block remains in WAIT until `gameEnd`.
- `gameEnd` in any state: -> HOST; clear `setWord`, count, mask, pending and `guess`.
- `setWord` is frozen outside HOST.

## Timing
- Reset values:
  - State HOST.
  - `setWord`=0, `guess`=0, `toggle_state`=0, `letter_count`=0, `dup_guess`=0, `host_mode`=1.
  - Mask and pending cleared.
- All outputs are registered.
- HOST keystroke: `setWord` and `letter_count` update at the edge that samples the strobe.
- `key_enter` at count 5, sampled at edge N: `toggle_state` high for cycle N+1 only; PLAY from N+2.
- Key sampled in PLAY at edge N with `game_rdy`=1 and `red_busy`=0: pending set at N. `guess` is non-zero during cycle N+1→N+2 and zero afterwards. Min key-to-guess latency is 2 edges.
- `guess` is never non-zero on two consecutive cycles. No new guess is issued until `game_rdy` has been seen low.
- Reset mid-entry or mid-guess: asynchronous clear to the reset values; no pulse escapes.

## Structure
- `word_entry_pkg`:
  - State enum `entry_state_t`.
  - Constants `WORD_LEN`, `ASCII_A`=8'h41, `ASCII_Z`=8'h5A, `ASCII_CASE`=8'h20.
  - Shared with the game FSM for word-length agreement.
- Sub-module `ascii_letter_decode` (combinational): `key_code` -> {`is_letter`, upper[7:0], idx[4:0]}.
- Top level holds the FSM, shift register, count, 26-bit mask and pending register.

## Test plan
- Host types "h","e","l","l","o", then enter -> `setWord`=0x48454C4C4F, `letter_count`=5, one `toggle_state` pulse, `host_mode`=0.
- Host types "ABC", del, "D", enter -> enter ignored, `setWord`=0x0000414244, count 3, no pulse.
- PLAY with `game_rdy`=1: key 'e' -> `guess`=0x45 for exactly 1 cycle. Second key 'E' after `game_rdy` toggles 0→1 -> `dup_guess` pulse, `guess` stays 0.
- Key 'X' while `red_busy`=1; then 'Y' before ready -> single `guess`=0x59 once `game_rdy`=1 and `red_busy`=0.
- `gameEnd` during WAIT, and `nRst` low mid-entry at count 3 -> all outputs at reset values next cycle, state HOST.
- Simultaneous `key_enter` and `key_valid` at count 5 -> START taken, letter discarded, `setWord` unchanged.
